// File: rtl/cups_pipe_pkg.sv
// rtl/cups_pipe_pkg.sv - shared opcodes, field helpers and hazard-control state encoding
package cups_pipe_pkg;

  localparam logic [15:0] NOP = 16'h0000;

  localparam logic [3:0] OP_ADD  = 4'h0;
  localparam logic [3:0] OP_SUB  = 4'h1;
  localparam logic [3:0] OP_AND  = 4'h2;
  localparam logic [3:0] OP_OR   = 4'h3;
  localparam logic [3:0] OP_ADDI = 4'h4;
  localparam logic [3:0] OP_LW   = 4'h5;
  localparam logic [3:0] OP_SW   = 4'h6;
  localparam logic [3:0] OP_BRZ  = 4'h7;
  localparam logic [3:0] OP_JMP  = 4'h8;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_FLUSH = 2'd1,
    ST_IWAIT = 2'd2
  } hz_state_t;

  function automatic logic [3:0] f_opcode(input logic [15:0] instr);
    return instr[15:12];
  endfunction

  function automatic logic [3:0] f_rd(input logic [15:0] instr);
    return instr[11:8];
  endfunction

  function automatic logic [3:0] f_rs(input logic [15:0] instr);
    return instr[7:4];
  endfunction

  function automatic logic [3:0] f_rt(input logic [15:0] instr);
    return instr[3:0];
  endfunction

  // Only register-register ALU ops and stores read the rt field as a source.
  function automatic logic uses_rt(input logic [3:0] opcode);
    return (opcode == OP_ADD) || (opcode == OP_SUB) || (opcode == OP_AND) ||
           (opcode == OP_OR)  || (opcode == OP_SW);
  endfunction

endpackage

// File: rtl/load_use_detect.sv
// rtl/load_use_detect.sv - flags a load in ID/EX whose result the IF/ID instruction reads
module load_use_detect
  import cups_pipe_pkg::*;
(
  input  logic [15:0] ifid_instr,
  input  logic        idex_memread,
  input  logic [3:0]  idex_rd,
  output logic        hazard
);

  logic rs_hit;
  logic rt_hit;
  logic is_nop;

  assign rs_hit = (idex_rd == f_rs(ifid_instr));
  assign rt_hit = uses_rt(f_opcode(ifid_instr)) && (idex_rd == f_rt(ifid_instr));
  // A flushed slot never interlocks; its source fields are r0 anyway.
  assign is_nop = (ifid_instr == NOP) && (f_rd(ifid_instr) == 4'd0);

  assign hazard = idex_memread && (idex_rd != 4'd0) && !is_nop && (rs_hit || rt_hit);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// rtl/pipe_hazard_ctrl.sv - stall/flush/bubble sequencing for the front of the 16-bit pipeline
module pipe_hazard_ctrl
  import cups_pipe_pkg::*;
#(
  parameter int BR_PENALTY = 2,
  parameter int WAIT_MAX   = 15,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [15:0]      ifid_instr,
  input  logic             idex_memread,
  input  logic [3:0]       idex_rd,
  input  logic             ex_br_taken,
  input  logic             imem_ready,
  input  logic             perf_clr,
  output logic             pc_stall,
  output logic             ifid_stall,
  output logic             ifid_flush,
  output logic             idex_bubble,
  output logic             imem_timeout,
  output logic [CNT_W-1:0] stall_cycles
);

  localparam int BR_W   = (BR_PENALTY > 2) ? $clog2(BR_PENALTY - 1) : 1;
  localparam int WAIT_W = $clog2(WAIT_MAX + 1);
  localparam logic [BR_W-1:0]   BR_RELOAD = BR_W'((BR_PENALTY > 1) ? BR_PENALTY - 2 : 0);
  localparam logic [WAIT_W-1:0] WAIT_LIM  = WAIT_W'(WAIT_MAX);

  hz_state_t         state, state_nx;
  logic [BR_W-1:0]   br_cnt, br_cnt_nx;
  logic [WAIT_W-1:0] wait_cnt, wait_cnt_nx;
  logic              timeout_nx;
  logic [CNT_W-1:0]  stall_nx;
  logic              hazard;

  load_use_detect u_load_use_detect (
    .ifid_instr   (ifid_instr),
    .idex_memread (idex_memread),
    .idex_rd      (idex_rd),
    .hazard       (hazard)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= ST_RUN;
      br_cnt       <= '0;
      wait_cnt     <= '0;
      imem_timeout <= 1'b0;
      stall_cycles <= '0;
    end else begin
      state        <= state_nx;
      br_cnt       <= br_cnt_nx;
      wait_cnt     <= wait_cnt_nx;
      imem_timeout <= timeout_nx;
      stall_cycles <= stall_nx;
    end
  end

  always_comb begin
    state_nx    = state;
    br_cnt_nx   = br_cnt;
    wait_cnt_nx = '0;
    timeout_nx  = imem_timeout;
    pc_stall    = 1'b0;
    ifid_stall  = 1'b0;
    ifid_flush  = 1'b0;
    idex_bubble = 1'b0;
    stall_nx    = stall_cycles;

    case (state)
      ST_RUN: begin
        if (ex_br_taken) begin
          if (BR_PENALTY > 1) begin
            state_nx  = ST_FLUSH;
            br_cnt_nx = BR_RELOAD;
          end
        end else if (!imem_ready) begin
          state_nx = ST_IWAIT;
        end
      end
      ST_FLUSH: begin
        if (ex_br_taken) begin
          br_cnt_nx = BR_RELOAD;
        end else if (br_cnt == '0) begin
          state_nx = imem_ready ? ST_RUN : ST_IWAIT;
        end else begin
          br_cnt_nx = br_cnt - BR_W'(1);
        end
      end
      ST_IWAIT: begin
        if (ex_br_taken) begin
          state_nx  = (BR_PENALTY > 1) ? ST_FLUSH : ST_RUN;
          br_cnt_nx = BR_RELOAD;
        end else if (imem_ready) begin
          state_nx = ST_RUN;
        end else begin
          wait_cnt_nx = (wait_cnt == WAIT_LIM) ? wait_cnt : wait_cnt + WAIT_W'(1);
          if (wait_cnt_nx == WAIT_LIM) timeout_nx = 1'b1;
        end
      end
      default: state_nx = ST_RUN;
    endcase

    // Branch outranks fetch wait, which outranks load-use; all forced low in reset.
    if (reset) begin
      if (ex_br_taken) begin
        ifid_flush  = 1'b1;
        idex_bubble = 1'b1;
      end else if (state == ST_FLUSH) begin
        ifid_flush = 1'b1;
        pc_stall   = !imem_ready;
      end else if (state == ST_IWAIT || !imem_ready) begin
        pc_stall   = 1'b1;
        ifid_flush = 1'b1;
      end else if (hazard) begin
        pc_stall    = 1'b1;
        ifid_stall  = 1'b1;
        idex_bubble = 1'b1;
      end
    end

    if (perf_clr) begin
      stall_nx = '0;
    end else if ((pc_stall || ifid_flush) && (stall_cycles != '1)) begin
      stall_nx = stall_cycles + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb/tb_pipe_hazard_ctrl.sv - scoreboard bench for pipe_hazard_ctrl against a behavioural model
module tb_pipe_hazard_ctrl;
  import cups_pipe_pkg::*;

  localparam int BRP  = 2;
  localparam int WMAX = 15;
  localparam int CW   = 5;
  localparam int SMAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic [15:0]   ifid_instr = NOP;
  logic          idex_memread = 1'b0;
  logic [3:0]    idex_rd = 4'd0;
  logic          ex_br_taken = 1'b0;
  logic          imem_ready = 1'b1;
  logic          perf_clr = 1'b0;
  logic          pc_stall, ifid_stall, ifid_flush, idex_bubble, imem_timeout;
  logic [CW-1:0] stall_cycles;

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(.BR_PENALTY(BRP), .WAIT_MAX(WMAX), .CNT_W(CW)) dut (
    .clk          (clk),
    .reset        (reset),
    .ifid_instr   (ifid_instr),
    .idex_memread (idex_memread),
    .idex_rd      (idex_rd),
    .ex_br_taken  (ex_br_taken),
    .imem_ready   (imem_ready),
    .perf_clr     (perf_clr),
    .pc_stall     (pc_stall),
    .ifid_stall   (ifid_stall),
    .ifid_flush   (ifid_flush),
    .idex_bubble  (idex_bubble),
    .imem_timeout (imem_timeout),
    .stall_cycles (stall_cycles)
  );

  typedef struct packed {
    logic          pc;
    logic          is;
    logic          fl;
    logic          bu;
    logic          to;
    logic [CW-1:0] sc;
  } exp_t;

  exp_t q[$];
  int   vectors = 0;
  int   miscompares = 0;

  // Reference model: flush cycles still owed, whether a fetch is outstanding, etc.
  int   m_flush_left = 0;
  int   m_waited = 0;
  bit   m_waiting = 0;
  bit   m_to = 0;
  int   m_perf = 0;

  function automatic bit reads_rt(input logic [3:0] op);
    return op inside {OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SW};
  endfunction

  task automatic step(input bit rst_n, input bit mr, input logic [3:0] rd,
                      input logic [15:0] ins, input bit br, input bit rdy, input bit clr);
    exp_t e;
    bit   hz;
    @(posedge clk);
    #1;
    reset = rst_n; idex_memread = mr; idex_rd = rd; ifid_instr = ins;
    ex_br_taken = br; imem_ready = rdy; perf_clr = clr;
    e = '0;
    if (!rst_n) begin
      m_flush_left = 0; m_waited = 0; m_waiting = 0; m_to = 0; m_perf = 0;
      q.push_back(e);
      return;
    end
    hz = mr && (rd != 0) && ((rd == ins[7:4]) || (reads_rt(ins[15:12]) && rd == ins[3:0]));
    e.to = m_to;
    e.sc = CW'(m_perf);
    if (br) begin
      e.fl = 1; e.bu = 1;
    end else if (m_flush_left > 0) begin
      e.fl = 1; e.pc = !rdy;
    end else if (m_waiting || !rdy) begin
      e.pc = 1; e.fl = 1;
    end else if (hz) begin
      e.pc = 1; e.is = 1; e.bu = 1;
    end
    q.push_back(e);
    if (clr) m_perf = 0;
    else if ((e.pc || e.fl) && m_perf < SMAX) m_perf++;
    if (br) begin
      m_flush_left = BRP - 1; m_waiting = 0; m_waited = 0;
    end else if (m_flush_left > 0) begin
      m_flush_left--;
      if (m_flush_left == 0) m_waiting = !rdy;
    end else if (m_waiting) begin
      if (rdy) begin
        m_waiting = 0; m_waited = 0;
      end else begin
        if (m_waited < WMAX) m_waited++;
        if (m_waited == WMAX) m_to = 1;
      end
    end else begin
      m_waiting = !rdy;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1, 0, 4'd0, NOP, 0, 1, 0);
  endtask

  always @(negedge clk) begin
    exp_t e;
    exp_t a;
    if (q.size() > 0) begin
      e = q.pop_front();
      a = {pc_stall, ifid_stall, ifid_flush, idex_bubble, imem_timeout, stall_cycles};
      vectors++;
      if (a !== e) begin
        miscompares++;
        $display("FAIL ctrl_vec %0d at %0t: got pc=%b is=%b fl=%b bu=%b to=%b sc=%0d, want pc=%b is=%b fl=%b bu=%b to=%b sc=%0d",
                 vectors, $time, a.pc, a.is, a.fl, a.bu, a.to, a.sc, e.pc, e.is, e.fl, e.bu, e.to, e.sc);
      end
    end
  end

  initial begin
    step(0, 0, 4'd0, NOP, 0, 1, 0);
    step(0, 1, 4'd3, {OP_ADD, 4'd5, 4'd3, 4'd1}, 1, 0, 0);
    step(1, 0, 4'd0, NOP, 0, 1, 0);
    idle(1);
    // load-use on rs, then the interlock resolves
    step(1, 1, 4'd3, {OP_ADD, 4'd5, 4'd3, 4'd1}, 0, 1, 0);
    step(1, 0, 4'd3, {OP_ADD, 4'd5, 4'd3, 4'd1}, 0, 1, 0);
    idle(1);
    // r0 never interlocks; rt only counts when the opcode reads it
    step(1, 1, 4'd0, {OP_ADD, 4'd5, 4'd0, 4'd1}, 0, 1, 0);
    step(1, 1, 4'd3, {OP_LW, 4'd5, 4'd1, 4'd3}, 0, 1, 0);
    step(1, 1, 4'd3, {OP_ADDI, 4'd5, 4'd1, 4'd3}, 0, 1, 0);
    step(1, 1, 4'd3, {OP_SW, 4'd5, 4'd1, 4'd3}, 0, 1, 0);
    step(1, 0, 4'd3, {OP_SW, 4'd5, 4'd1, 4'd3}, 0, 1, 0);
    // taken branch, then branch coinciding with a load-use
    step(1, 0, 4'd0, NOP, 1, 1, 0);
    idle(2);
    step(1, 1, 4'd2, {OP_OR, 4'd1, 4'd2, 4'd2}, 1, 1, 0);
    idle(2);
    // long instruction-memory wait
    for (int i = 0; i < 20; i++) step(1, 0, 4'd0, NOP, 0, 0, 0);
    idle(3);
    // reset in the middle of a fetch wait, then clear-versus-increment
    step(1, 0, 4'd0, NOP, 0, 1, 1);
    for (int i = 0; i < 7; i++) step(1, 0, 4'd0, NOP, 0, 0, 0);
    step(0, 0, 4'd0, NOP, 0, 0, 0);
    step(0, 0, 4'd0, NOP, 0, 0, 0);
    step(1, 0, 4'd0, NOP, 0, 0, 1);
    idle(2);
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 499) != 0), 1'($urandom_range(0, 1)), 4'($urandom_range(0, 3)),
           {4'($urandom_range(0, 15)), 4'($urandom), 4'($urandom_range(0, 3)), 4'($urandom_range(0, 3))},
           ($urandom_range(0, 9) == 0), ($urandom_range(0, 5) != 0), ($urandom_range(0, 63) == 0));
    end
    idle(1);
    @(posedge clk);
    @(negedge clk);
    #1;
    if (q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: %0d expected vectors left unchecked, want 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
